// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: boot address default, fetch buffer sizing
// and the {pc,inst} entry carried from instruction memory to IF/ID.
package cpu_pkg;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam int          FIFO_DEPTH        = 2;
  localparam int          MAX_OUTSTANDING   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order response buffer for the fetch unit; entry 0 is always the
// head. Flush wins over push/pop, and push+pop on a full buffer is lossless.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic [1:0]  count
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d, new_e;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  assign new_e   = '{pc: push_pc, inst: push_inst};
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'(FIFO_DEPTH)) || pop_ok);

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) e0_d = new_e;
          else                 e1_d = new_e;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = new_e;
          end else begin
            e0_d = e1_q;
            e1_d = new_e;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= 2'd0;
    else      count_q <= count_d;
  end

  // Payload needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign head_pc   = e0_q.pc;
  assign head_inst = e0_q.inst;
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word requests, pairs in-order responses with
// their PCs and feeds IF/ID. Define INST_FETCH_EXC_EN to add flush_i/new_pc_i.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
`ifdef INST_FETCH_EXC_EN
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
`endif
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stallreq_o
);

  logic [31:0] fetch_pc_q, fetch_pc_d, pend_addr_q, pend_addr_d;
  logic [31:0] opc0_q, opc0_d, opc1_q, opc1_d;
  logic [1:0]  outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic        pend_q, pend_d, pend_stale_q, pend_stale_d;

  logic        redirect, out_block;
  logic [31:0] redirect_pc;
  logic [1:0]  fifo_count;
  logic [31:0] head_pc, head_inst;
  logic        fifo_empty, issue_ok, new_req, grant, stale_grant;
  logic        rvalid_eff, drop_resp, push, pop;
  logic [2:0]  in_use;
  logic        unused_stall;

  assign unused_stall = ^stall[5:2];

`ifdef INST_FETCH_EXC_EN
  assign redirect    = flush_i | (branch_flag_i & ~stall[0]);
  assign redirect_pc = flush_i ? new_pc_i : branch_target_addr_i;
  assign out_block   = flush_i;
`else
  assign redirect    = branch_flag_i & ~stall[0];
  assign redirect_pc = branch_target_addr_i;
  assign out_block   = 1'b0;
`endif

  assign fifo_empty = (fifo_count == 2'd0);
  assign in_use     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign issue_ok   = in_use < 3'(MAX_OUTSTANDING);
  assign new_req    = rst & ~stall[0] & issue_ok & ~redirect;

  // A request left ungranted stays up with its address, even across a redirect;
  // such a stale request is dropped once granted.
  assign rom_req_o   = pend_q | new_req;
  assign rom_addr_o  = pend_q ? pend_addr_q : fetch_pc_q;
  assign grant       = rom_req_o & rom_gnt_i;
  assign stale_grant = grant & pend_q & pend_stale_q;

  assign rvalid_eff = rom_rvalid_i & (outstanding_q != 2'd0);
  assign drop_resp  = rvalid_eff & (drop_cnt_q != 2'd0);
  assign push       = rvalid_eff & ~drop_resp & ~redirect;

  assign if_valid   = ~fifo_empty & ~out_block;
  assign if_pc      = if_valid ? head_pc : 32'h0;
  assign if_inst    = if_valid ? head_inst : 32'h0;
  assign pop        = if_valid & ~stall[1] & ~redirect;
  assign stallreq_o = rst & fifo_empty & ~stall[1];

  always_comb begin
    outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rvalid_eff};

    fetch_pc_d = fetch_pc_q;
    if (redirect)                   fetch_pc_d = redirect_pc;
    else if (grant && !stale_grant) fetch_pc_d = rom_addr_o + 32'd4;

    if (redirect) drop_cnt_d = outstanding_d;
    else          drop_cnt_d = drop_cnt_q - {1'b0, drop_resp} + {1'b0, stale_grant};

    pend_d       = rom_req_o & ~rom_gnt_i;
    pend_addr_d  = rom_addr_o;
    pend_stale_d = pend_d & (redirect | (pend_q & pend_stale_q));

    // PCs of granted-but-unanswered requests, oldest in opc0.
    opc0_d = opc0_q;
    opc1_d = opc1_q;
    if (rvalid_eff) opc0_d = opc1_q;
    if (grant) begin
      if ((outstanding_q - {1'b0, rvalid_eff}) == 2'd0) opc0_d = rom_addr_o;
      else                                              opc1_d = rom_addr_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= BOOT_ADDR;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
      pend_q        <= 1'b0;
      pend_stale_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      pend_q        <= pend_d;
      pend_stale_q  <= pend_stale_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    opc0_q      <= opc0_d;
    opc1_q      <= opc1_d;
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (opc0_q),
    .push_inst (rom_rdata_i),
    .pop       (pop),
    .flush     (redirect),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency instruction memory.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stallreq_o;
`ifdef INST_FETCH_EXC_EN
  logic        flush_i;
  logic [31:0] new_pc_i;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] gq[$];
  logic        resp_en;

  always #5 clk = ~clk;

  inst_fetch #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
`ifdef INST_FETCH_EXC_EN
    .flush_i              (flush_i),
    .new_pc_i             (new_pc_i),
`endif
    .rom_req_o            (rom_req_o),
    .rom_addr_o           (rom_addr_o),
    .rom_gnt_i            (rom_gnt_i),
    .rom_rvalid_i         (rom_rvalid_i),
    .rom_rdata_i          (rom_rdata_i),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_valid             (if_valid),
    .stallreq_o           (stallreq_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record a grant, then return the oldest granted word if enabled.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = rom_req_o && rom_gnt_i;
    a = rom_addr_o;
    if (g) gq.push_back(a);
    @(posedge clk);
    #1;
    if (resp_en && gq.size() != 0) begin
      rom_rvalid_i = 1'b1;
      rom_rdata_i  = inst_of(gq.pop_front());
    end else begin
      rom_rvalid_i = 1'b0;
      rom_rdata_i  = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0;
    gq.delete();
    tick();
  endtask

  initial begin
    rst = 1'b0; stall = 6'b0; branch_flag_i = 1'b0; branch_target_addr_i = 32'h0;
    rom_gnt_i = 1'b1; rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0; resp_en = 1'b1;
`ifdef INST_FETCH_EXC_EN
    flush_i = 1'b0; new_pc_i = 32'h0;
`endif
    #1;
    check("rst_req", rom_req_o, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 0);
    check("rst_inst", if_inst, 0);
    check("rst_stallreq", stallreq_o, 0);
    tick(); tick();

    // Zero-wait memory after reset release
    rst = 1'b1; #1;
    check("boot_req", rom_req_o, 1);
    check("boot_addr", rom_addr_o, 32'h0);
    check("boot_stallreq", stallreq_o, 1);
    tick(); #1;
    check("seq_addr4", rom_addr_o, 32'h4);
    check("seq_valid0", if_valid, 0);
    tick(); #1;
    check("seq_valid1", if_valid, 1);
    check("seq_pc0", if_pc, 32'h0);
    check("seq_inst0", if_inst, 32'hDEAD_0000);
    check("seq_noreq", rom_req_o, 0);
    tick(); #1;
    check("seq_addr8", rom_addr_o, 32'h8);
    check("seq_pc4", if_pc, 32'h4);

    // Fill the buffer, then freeze issue and output for three cycles
    stall = 6'b000010;
    tick(); tick();
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stl_req", rom_req_o, 0);
      check("stl_pc", if_pc, 32'h4);
      check("stl_inst", if_inst, 32'hDEAD_0004);
      tick();
    end
    stall = 6'b0; #1;
    check("res_pc4", if_pc, 32'h4);
    check("res_valid", if_valid, 1);
    tick(); #1;
    check("res_pc8", if_pc, 32'h8);
    check("res_inst8", if_inst, 32'hDEAD_0008);
    check("res_addrC", rom_addr_o, 32'hC);

    // Branch with two requests outstanding
    do_reset(); #1;
    check("mid_rst_req", rom_req_o, 0);
    check("mid_rst_valid", if_valid, 0);
    resp_en = 1'b0;
    rst = 1'b1;
    tick(); tick(); #1;
    check("br_full_req", rom_req_o, 0);
    branch_flag_i = 1'b1; branch_target_addr_i = 32'h100; resp_en = 1'b1; #1;
    check("br_cyc_req", rom_req_o, 0);
    tick();
    branch_flag_i = 1'b0; #1;
    check("br_drop1_req", rom_req_o, 0);
    check("br_drop1_valid", if_valid, 0);
    tick(); #1;
    check("br_new_req", rom_req_o, 1);
    check("br_new_addr", rom_addr_o, 32'h100);
    check("br_drop2_valid", if_valid, 0);
    tick(); #1;
    check("br_addr104", rom_addr_o, 32'h104);
    check("br_still_empty", if_valid, 0);
    tick(); #1;
    check("br_first_pc", if_pc, 32'h100);
    check("br_first_inst", if_inst, 32'hDEAD_0100);

    // Branch while issue is frozen must be ignored
    stall = 6'b000001; branch_flag_i = 1'b1; branch_target_addr_i = 32'h200; #1;
    check("brstl_req", rom_req_o, 0);
    tick();
    stall = 6'b0; branch_flag_i = 1'b0; #1;
    check("brstl_addr", rom_addr_o, 32'h108);
    check("brstl_pc", if_pc, 32'h104);

    // No grants: request held, fetch starved
    do_reset();
    rom_gnt_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stall = (i == 2) ? 6'b000001 : 6'b000000;
      #1;
      check("ng_stallreq", stallreq_o, 1);
      check("ng_inst", if_inst, 0);
      check("ng_valid", if_valid, 0);
      check("ng_req_held", rom_req_o, 1);
      check("ng_addr_held", rom_addr_o, 32'h0);
      tick();
    end
    stall = 6'b0;

    // Address wrap at the top of memory
    do_reset();
    rom_gnt_i = 1'b1;
    rst = 1'b1;
    branch_flag_i = 1'b1; branch_target_addr_i = 32'hFFFF_FFFC; #1;
    check("wr_redir_req", rom_req_o, 0);
    tick();
    branch_flag_i = 1'b0; #1;
    check("wr_top_req", rom_req_o, 1);
    check("wr_top_addr", rom_addr_o, 32'hFFFF_FFFC);
    tick(); #1;
    check("wr_wrap_addr", rom_addr_o, 32'h0);
    tick(); #1;
    check("wr_pc", if_pc, 32'hFFFF_FFFC);
    check("wr_inst", if_inst, 32'hDEAD_FFFC);

`ifdef INST_FETCH_EXC_EN
    // Flush overrides branch and stall
    flush_i = 1'b1; new_pc_i = 32'h180;
    branch_flag_i = 1'b1; branch_target_addr_i = 32'h100; stall = 6'b000011; #1;
    check("fl_valid", if_valid, 0);
    check("fl_req", rom_req_o, 0);
    tick();
    flush_i = 1'b0; branch_flag_i = 1'b0; stall = 6'b0; #1;
    check("fl_addr", rom_addr_o, 32'h180);
    check("fl_req_after", rom_req_o, 1);
    check("fl_empty", if_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, which is the PC loaded at reset.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, asynchronous reset, active-low).
REQ-003 SHALL have port stall (in, 6): stall[0] freezes request issue; stall[1] holds the IF/ID output.
REQ-004 SHALL have ports branch_flag_i (in, 1) and branch_target_addr_i (in, 32), the ID-stage redirect.
REQ-005 SHALL have ports rom_req_o (out, 1) and rom_addr_o (out, 32), the instruction-memory request and word address.
REQ-006 SHALL have port rom_gnt_i (in, 1), which accepts a request in the cycle where rom_req_o=1.
REQ-007 SHALL have ports rom_rvalid_i (in, 1) and rom_rdata_i (in, 32); responses return in request order, at least 1 cycle after grant.
REQ-008 SHALL have ports if_pc (out, 32), if_inst (out, 32) and if_valid (out, 1), which feed the IF/ID register.
REQ-009 SHALL have port stallreq_o (out, 1), which requests a pipeline stall while no instruction is available.

Function
REQ-010 SHALL keep fetch_pc, the address of the next request; each grant advances fetch_pc by 4 with 32-bit wrap (32'hFFFF_FFFC to 0).
REQ-011 SHALL track outstanding requests (0..2) and a 2-entry {pc,inst} response FIFO, issuing only while outstanding+fifo_count < 2.
REQ-012 SHALL assert rom_req_o only when stall[0]=0, the issue condition holds, and no redirect is being applied that cycle.
REQ-013 SHALL hold rom_req_o and rom_addr_o stable until granted.
REQ-014 SHALL push each non-dropped response onto the FIFO tail, pairing it with its request PC.
REQ-015 SHALL present the FIFO head on if_pc/if_inst with if_valid=1; when the FIFO is empty, if_pc=0, if_inst=0 (NOP) and if_valid=0.
REQ-016 SHALL pop the head when if_valid=1 and stall[1]=0.
REQ-017 SHALL allow a push and a pop in the same cycle on a full FIFO without loss.
REQ-018 SHALL drive stallreq_o=1 when the FIFO is empty and stall[1]=0.
REQ-019 SHALL apply a redirect when branch_flag_i=1 and stall[0]=0: fetch_pc<=branch_target_addr_i, FIFO cleared, drop_cnt<=outstanding.
REQ-020 SHALL include a grant arriving in the redirect cycle in drop_cnt.
REQ-021 SHALL, while drop_cnt>0, discard each rom_rvalid_i and decrement drop_cnt instead of pushing.
REQ-022 SHALL give a redirect priority over a simultaneous pop; the popped instruction is still consumed by IF/ID that cycle.
REQ-023 SHALL allow the first post-redirect request in the cycle after the redirect.
REQ-024 SHALL ignore branch_flag_i while stall[0]=1.
REQ-025 SHALL ignore rom_rvalid_i when no request is outstanding, and assert no error.

Reset
REQ-026 SHALL, while rst=0, drive fetch_pc=BOOT_ADDR, outstanding=0, drop_cnt=0, FIFO empty, rom_req_o=0, if_valid=0, if_pc=0, if_inst=0, stallreq_o=0.
REQ-027 SHALL, on reset mid-transaction, discard all in-flight responses; the memory side is reset concurrently.
REQ-028 SHALL raise the first rom_req_o, with rom_addr_o=BOOT_ADDR, on the first clock edge after rst deasserts.

Configuration
REQ-029 SHALL, with INST_FETCH_EXC_EN defined, add inputs flush_i (1) and new_pc_i (32).
REQ-030 SHALL, with INST_FETCH_EXC_EN, treat flush_i=1 as a redirect to new_pc_i regardless of stall; it overrides branch_flag_i and forces if_valid=0 that cycle.
REQ-031 SHALL, without INST_FETCH_EXC_EN, omit those ports and the flush logic.

Structure
REQ-032 SHALL place BOOT_ADDR default, the FIFO depth constant (2), the max-outstanding constant (2) and a fetch_entry_t {pc,inst} typedef in shared package cpu_pkg.
REQ-033 SHALL implement the response FIFO as sub-module fetch_fifo (depth 2, push/pop/flush, count output).

Verification
REQ-034 Reset then release, zero-wait memory -> rom_addr_o 0,4,8 on consecutive grants; if_pc 0 valid 2 cycles after the first grant.
REQ-035 stall=6'b000011 for 3 cycles with FIFO full -> no new rom_req_o; if_pc/if_inst held; resume without loss or duplication.
REQ-036 branch_flag_i=1, target 32'h100, with 2 outstanding -> both responses dropped; next rom_addr_o=32'h100; if_pc=32'h100 is the first valid output.
REQ-037 FIFO empty with rom_gnt_i=0 for 4 cycles -> stallreq_o=1, if_inst=0, if_valid=0 throughout.
REQ-038 fetch_pc=32'hFFFF_FFFC granted -> next rom_addr_o=32'h0.
REQ-039 INST_FETCH_EXC_EN build: flush_i=1, new_pc_i=32'h180, together with branch_flag_i=1 -> redirect to 32'h180 and FIFO emptied.
